// File: rtl/route_sweep_scheduler.sv
// Sweep scheduler: walks a configuration index from first to last (wrapping
// through 0xFFFF), settling after every select change and dwelling in RUN
// while strobing FIFO reads.
module route_sweep_scheduler #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        inClock,
  input  logic        inReset,
  input  logic        inStart,
  input  logic        inAbort,
  input  logic        inPause,
  input  logic [15:0] inFirst,
  input  logic [15:0] inLast,
  input  logic [15:0] inDwell,
  input  logic        inFifoEmpty,
  input  logic        inFifoFull,
  output logic [2:0]  outSEL1,
  output logic [2:0]  outSEL2,
  output logic        outSEL3,
  output logic [1:0]  outSEL6,
  output logic [1:0]  outSEL9,
  output logic        outSEL11,
  output logic        outSEL12,
  output logic [2:0]  outSEL15,
  output logic        outSEL17,
  output logic        outReadEnable,
  output logic        outBusy,
  output logic        outDone,
  output logic [15:0] outIndex
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RUN} state_t;

  localparam logic [3:0] LP_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      r_state, w_state;
  logic [15:0] r_idx, w_idx;
  logic [15:0] r_last, w_last;
  logic [15:0] r_dwell, w_dwell;
  logic [3:0]  r_settle_cnt, w_settle_cnt;
  logic [15:0] r_run_cnt, w_run_cnt;
  logic        r_done, w_done;

  // State and sweep context registers; reset clears everything immediately.
  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_last       <= '0;
      r_dwell      <= '0;
      r_settle_cnt <= '0;
      r_run_cnt    <= '0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_idx        <= w_idx;
      r_last       <= w_last;
      r_dwell      <= w_dwell;
      r_settle_cnt <= w_settle_cnt;
      r_run_cnt    <= w_run_cnt;
      r_done       <= w_done;
    end
  end

  // Next-state logic; abort overrides everything and leaves the index held.
  always_comb begin
    w_state      = r_state;
    w_idx        = r_idx;
    w_last       = r_last;
    w_dwell      = r_dwell;
    w_settle_cnt = r_settle_cnt;
    w_run_cnt    = r_run_cnt;
    w_done       = 1'b0;
    if (inAbort) begin
      w_state      = S_IDLE;
      w_settle_cnt = '0;
      w_run_cnt    = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (inStart) begin
            w_state      = S_SETTLE;
            w_idx        = inFirst;
            w_last       = inLast;
            w_dwell      = (inDwell == 16'd0) ? 16'd1 : inDwell;
            w_settle_cnt = '0;
            w_run_cnt    = '0;
          end
        end
        S_SETTLE: begin
          // Pause has no effect here: the datapath must settle regardless.
          if (r_settle_cnt == LP_SETTLE_LAST) begin
            w_state      = S_RUN;
            w_settle_cnt = '0;
            w_run_cnt    = '0;
          end else begin
            w_settle_cnt = r_settle_cnt + 4'd1;
          end
        end
        S_RUN: begin
          if (!inPause) begin
            if (r_run_cnt == r_dwell - 16'd1) begin
              w_run_cnt = '0;
              if (r_idx == r_last) begin
                w_state = S_IDLE;
                w_done  = 1'b1;
              end else begin
                w_state      = S_SETTLE;
                w_idx        = r_idx + 16'd1;
                w_settle_cnt = '0;
              end
            end else begin
              w_run_cnt = r_run_cnt + 16'd1;
            end
          end
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  assign outIndex      = r_idx;
  assign outBusy       = (r_state != S_IDLE);
  assign outDone       = r_done;
  assign outReadEnable = (r_state == S_RUN) & ~inPause & ~inFifoEmpty & ~inFifoFull;

  // Datapath selects are pure bit slices of the registered index.
  assign outSEL17 = r_idx[0];
  assign outSEL15 = {1'b0, r_idx[2:1]};
  assign outSEL12 = r_idx[3];
  assign outSEL11 = r_idx[4];
  assign outSEL9  = r_idx[6:5];
  assign outSEL6  = r_idx[8:7];
  assign outSEL3  = r_idx[9];
  assign outSEL2  = r_idx[12:10];
  assign outSEL1  = r_idx[15:13];

endmodule

// File: tb/tb_route_sweep_scheduler.sv
// Directed bench for route_sweep_scheduler with hand-computed expectations.
module tb_route_sweep_scheduler;

  logic        inClock = 1'b0;
  logic        inReset = 1'b0;
  logic        inStart = 1'b0;
  logic        inAbort = 1'b0;
  logic        inPause = 1'b0;
  logic [15:0] inFirst = '0;
  logic [15:0] inLast  = '0;
  logic [15:0] inDwell = '0;
  logic        inFifoEmpty = 1'b0;
  logic        inFifoFull  = 1'b0;
  logic [2:0]  outSEL1, outSEL2, outSEL15;
  logic [1:0]  outSEL6, outSEL9;
  logic        outSEL3, outSEL11, outSEL12, outSEL17;
  logic        outReadEnable, outBusy, outDone;
  logic [15:0] outIndex;

  int checks = 0;
  int failures = 0;

  route_sweep_scheduler #(.SETTLE_CYCLES(2)) dut (
    .inClock(inClock), .inReset(inReset), .inStart(inStart), .inAbort(inAbort),
    .inPause(inPause), .inFirst(inFirst), .inLast(inLast), .inDwell(inDwell),
    .inFifoEmpty(inFifoEmpty), .inFifoFull(inFifoFull),
    .outSEL1(outSEL1), .outSEL2(outSEL2), .outSEL3(outSEL3), .outSEL6(outSEL6),
    .outSEL9(outSEL9), .outSEL11(outSEL11), .outSEL12(outSEL12),
    .outSEL15(outSEL15), .outSEL17(outSEL17),
    .outReadEnable(outReadEnable), .outBusy(outBusy), .outDone(outDone),
    .outIndex(outIndex)
  );

  always #5 inClock = ~inClock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge inClock);
    #1;
  endtask

  task automatic start_sweep(input logic [15:0] f, input logic [15:0] l, input logic [15:0] d);
    inFirst = f; inLast = l; inDwell = d; inStart = 1'b1;
    cyc();
    inStart = 1'b0;
    // scramble config inputs: the running sweep must ignore them
    inFirst = 16'h1234; inLast = 16'h4321; inDwell = 16'd9;
  endtask

  initial begin
    int reads;
    // reset state
    #12;
    chk("rst_idx", 32'(outIndex), 32'h0);
    chk("rst_busy", 32'(outBusy), 32'h0);
    chk("rst_done", 32'(outDone), 32'h0);
    chk("rst_re", 32'(outReadEnable), 32'h0);
    chk("rst_sel", 32'({outSEL1, outSEL2, outSEL3, outSEL6, outSEL9, outSEL11,
                        outSEL12, outSEL15, outSEL17}), 32'h0);
    inReset = 1'b1;
    cyc();

    // basic two-config sweep, dwell 3
    start_sweep(16'd0, 16'd1, 16'd3);
    reads = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      chk($sformatf("t1_re_c%0d", c), 32'(outReadEnable),
          32'((c >= 2 && c <= 4) || (c >= 7 && c <= 9)));
      chk($sformatf("t1_busy_c%0d", c), 32'(outBusy), 32'(c < 10));
      chk($sformatf("t1_done_c%0d", c), 32'(outDone), 32'(c == 10));
      chk($sformatf("t1_idx_c%0d", c), 32'(outIndex), (c < 5) ? 32'd0 : 32'd1);
      if (outReadEnable) reads++;
      cyc();
    end
    chk("t1_reads", 32'(reads), 32'd6);
    chk("t1_sel17_held", 32'(outSEL17), 32'd1);

    // select mapping, single configuration
    start_sweep(16'hE3A5, 16'hE3A5, 16'd1);
    #1;
    chk("t2_sel1", 32'(outSEL1), 32'd7);
    chk("t2_sel2", 32'(outSEL2), 32'd0);
    chk("t2_sel3", 32'(outSEL3), 32'd1);
    chk("t2_sel6", 32'(outSEL6), 32'd3);
    chk("t2_sel9", 32'(outSEL9), 32'd1);
    chk("t2_sel11", 32'(outSEL11), 32'd0);
    chk("t2_sel12", 32'(outSEL12), 32'd0);
    chk("t2_sel15", 32'(outSEL15), 32'd2);
    chk("t2_sel17", 32'(outSEL17), 32'd1);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("t2_done_c%0d", c), 32'(outDone), 32'(c == 3));
      chk($sformatf("t2_re_c%0d", c), 32'(outReadEnable), 32'(c == 2));
      cyc();
    end
    chk("t2_idx_held", 32'(outIndex), 32'hE3A5);

    // wrap through 0xFFFF, dwell 0 treated as 1
    start_sweep(16'hFFFF, 16'h0000, 16'd0);
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("t3_idx_c%0d", c), 32'(outIndex), (c < 3) ? 32'hFFFF : 32'h0);
      chk($sformatf("t3_re_c%0d", c), 32'(outReadEnable), 32'(c == 2 || c == 5));
      chk($sformatf("t3_done_c%0d", c), 32'(outDone), 32'(c == 6));
      chk($sformatf("t3_busy_c%0d", c), 32'(outBusy), 32'(c < 6));
      cyc();
    end

    // pause stretches RUN; read only when unpaused and FIFO non-empty
    start_sweep(16'd7, 16'd7, 16'd4);
    begin
      logic [6:0] pz, em;
      pz = 7'b0010110; // bit k = RUN cycle k
      em = 7'b0100101;
      for (int c = 0; c < 11; c++) begin
        inPause     = (c == 1) ? 1'b1 : ((c >= 2 && c <= 8) ? pz[c-2] : 1'b0);
        inFifoEmpty = (c >= 2 && c <= 8) ? em[c-2] : 1'b0;
        #1;
        chk($sformatf("t4_busy_c%0d", c), 32'(outBusy), 32'(c < 9));
        chk($sformatf("t4_re_c%0d", c), 32'(outReadEnable), 32'(c == 5 || c == 8));
        chk($sformatf("t4_done_c%0d", c), 32'(outDone), 32'(c == 9));
        cyc();
      end
      inPause = 1'b0; inFifoEmpty = 1'b0;
    end

    // abort in RUN at index 5, restart one cycle later
    start_sweep(16'd3, 16'd9, 16'd2);
    for (int c = 0; c < 10; c++) cyc();
    inFifoFull = 1'b1;
    #1;
    chk("t5_idx5", 32'(outIndex), 32'd5);
    chk("t5_full_blocks_re", 32'(outReadEnable), 32'd0);
    cyc();
    inFifoFull = 1'b0; inAbort = 1'b1; inStart = 1'b1; inFirst = 16'd0;
    #1;
    chk("t5_re_before_abort", 32'(outReadEnable), 32'd1);
    cyc();
    inAbort = 1'b0; inStart = 1'b0;
    #1;
    chk("t5_abort_busy", 32'(outBusy), 32'd0);
    chk("t5_abort_done", 32'(outDone), 32'd0);
    chk("t5_abort_idx", 32'(outIndex), 32'd5);
    chk("t5_abort_sel17", 32'(outSEL17), 32'd1);
    start_sweep(16'h20, 16'h20, 16'd1);
    #1;
    chk("t5_restart_busy", 32'(outBusy), 32'd1);
    chk("t5_restart_idx", 32'(outIndex), 32'h20);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("t5_done_c%0d", c), 32'(outDone), 32'(c == 3));
      cyc();
    end

    // asynchronous reset mid-SETTLE
    start_sweep(16'hABCD, 16'hABCF, 16'd2);
    #3;
    inReset = 1'b0;
    #1;
    chk("t6_idx", 32'(outIndex), 32'h0);
    chk("t6_busy", 32'(outBusy), 32'h0);
    chk("t6_sel1", 32'(outSEL1), 32'h0);
    chk("t6_sel17", 32'(outSEL17), 32'h0);
    chk("t6_re", 32'(outReadEnable), 32'h0);
    chk("t6_done", 32'(outDone), 32'h0);
    cyc();
    inReset = 1'b1;
    begin
      int dones;
      int busies;
      dones = 0;
      busies = 0;
      for (int c = 0; c < 20; c++) begin
        cyc();
        if (outDone) dones++;
        if (outBusy) busies++;
      end
      chk("t6_no_done", 32'(dones), 32'd0);
      chk("t6_stays_idle", 32'(busies), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
